wb_row_arbiter: RTL and testbench
=================================

# wb_row_arbiter

Shares one feature-map buffer write port among the `CONF_PE_ROW` per-row write-back streams produced by the PE matrix's feature-map/guard generators. Arbitration is round-robin, one beat per grant. Each row has its own write-address counter. A `layer_done` pulse is issued once every row has signalled finish and all accepted data has drained. The block sits between the PE matrix write-back outputs and the feature-map buffer, and is sequenced by the layer controller via `start`.

## Interface
- `NUM_ROW`, 8: number of requesting rows (equals `CONF_PE_ROW`).
- `DATA_W`, 8: write-back data width.
- `ADDR_W`, 12: feature-map buffer address width.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; loads `base_addr`/`row_stride`, enters RUN; ignored unless IDLE.
- `base_addr`  in  ADDR_W  address of row 0's first beat.
- `row_stride`  in  ADDR_W  address offset between consecutive rows' regions.
- `row_valid`  in  NUM_ROW  per-row data valid.
- `row_data`  in  NUM_ROW×DATA_W  per-row data; row i at `[i*DATA_W +: DATA_W]`.
- `row_ready`  out  NUM_ROW  per-row accept, at most one bit set (one-hot or zero).
- `row_finish`  in  NUM_ROW  per-row finish pulse (from `write_back_finish`).
- `wr_valid`  out  1  buffer write valid (registered).
- `wr_addr`  out  ADDR_W  buffer write address (registered).
- `wr_data`  out  DATA_W  buffer write data (registered).
- `wr_ready`  in  1  buffer accepts the write.
- `busy`  out  1  high in RUN.
- `layer_done`  out  1  one-cycle pulse on completion.

## Operation
- FSM states and transitions:
  - IDLE → RUN on `start`.
  - RUN → DONE when all sticky finish bits are set and the output stage is empty (`!wr_valid`).
  - DONE → IDLE unconditionally after 1 cycle; `layer_done` = 1 in DONE only.
- On `start`:
  - `addr_cnt[i] = base_addr + i*row_stride`, computed modulo 2^ADDR_W.
  - Sticky finish bits cleared.
- Output stage: a single register holding `wr_valid`/`wr_addr`/`wr_data`.
  - `can_load` = `!wr_valid || wr_ready`.
- Arbitration (RUN only):
  - When `can_load`, the granted row is the first i with `row_valid[i]`, searching from `last_grant+1` upward and wrapping modulo NUM_ROW.
  - `row_ready[i]` = grant[i] & `can_load` (combinational from `row_valid`, `wr_valid`, `wr_ready`, `last_grant`).
  - A transfer occurs when `row_valid[i] && row_ready[i]`. On transfer:
    - The output stage loads `{addr_cnt[i], row_data[i]}`.
    - `addr_cnt[i]` increments by 1, wrapping at 2^ADDR_W.
    - `last_grant` ← i.
  - No requester valid: `last_grant` holds.
- `row_ready` is 0 in IDLE and DONE. `row_valid` is ignored there and no address counter changes.
- `row_finish[i]` sets sticky bit i in RUN only; a finish pulse in the same cycle as that row's last transfer is legal.
- A row that has finished may still present valid data; it is still arbitrated normally.
- Simultaneous `wr_ready` and new grant: the old beat retires and the new beat loads in the same cycle (full throughput, 1 beat/cycle).
- `start` in RUN/DONE is ignored; counters are unaffected.

## Timing
- Reset values (synchronous):
  - `wr_valid`, `wr_addr`, `wr_data`, `row_ready`, `busy`, `layer_done` = 0.
  - FSM = IDLE; `last_grant` = NUM_ROW-1, so row 0 has first priority.
  - Address counters and sticky bits = 0.
- Reset mid-RUN: the in-flight output beat is dropped and `layer_done` is not issued.
- Latency: a transfer at cycle N gives `wr_valid` at N+1.
- `wr_valid`/`wr_addr`/`wr_data` hold stable while `wr_valid && !wr_ready`.
- `busy` rises the cycle after `start`.
- `layer_done` is asserted one cycle after the completion condition is met, for exactly 1 cycle.
- Minimum `start`-to-`layer_done` with no data and all finishes arriving at cycle 1: 3 cycles.

## Configuration
- `WB_ROW_ARB_PERF_EN` defined:
  - Adds output `stall_cnt` (32 bits): counts RUN cycles with `wr_valid && !wr_ready`.
  - Cleared on `start` and on `rst`; saturates at 2^32-1.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- Reset then `start`, base=0x100, stride=0x40, all 8 rows continuously valid, `wr_ready`=1 → grants rows 0,1,…,7,0,…. The first 8 writes go to 0x100,0x140,…,0x2C0; the 9th goes to 0x101.
- Rows 2 and 5 only valid, `wr_ready` toggling 1/0 every cycle → grants alternate 2,5,2,5. No beat is lost or duplicated, and `wr_*` is stable during stalls.
- base=0xFFE, stride=0, row 0 sends 4 beats → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- All `row_finish` pulsed while 1 beat is held by `wr_ready`=0 for 5 cycles → `layer_done` fires 1 cycle after that beat retires, then `busy`=0.
- `start` pulsed during RUN and `row_valid` asserted in IDLE → no counter reload, `row_ready` stays 0 in IDLE.
- With `WB_ROW_ARB_PERF_EN`: 10 stalled cycles → `stall_cnt`=10; `rst` asserted mid-RUN → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/wb_row_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_row_arbiter
//  Description : Round-robin arbiter that funnels the per-row write-back
//                streams of the PE matrix into the single write port of the
//                feature-map buffer. One beat per grant, one independent
//                write-address counter per row, and a one-cycle layer_done
//                pulse once every row has finished and the output stage has
//                drained.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_ROW    number of requesting rows
//    DATA_W     write-back data width
//    ADDR_W     feature-map buffer address width
//  Ports
//    clk, rst           clock, synchronous active-high reset
//    start              pulse: load base_addr/row_stride, enter RUN (IDLE only)
//    base_addr          address of row 0's first beat
//    row_stride         address offset between consecutive rows' regions
//    row_valid/data     per-row write-back stream (row i at [i*DATA_W +: DATA_W])
//    row_ready          per-row accept, one-hot or zero
//    row_finish         per-row finish pulse
//    wr_valid/addr/data registered buffer write request
//    wr_ready           buffer accepts the write
//    busy               high while in RUN
//    layer_done         one-cycle completion pulse
//  Optional feature (macro WB_ROW_ARB_PERF_EN)
//    stall_cnt          saturating count of RUN cycles with wr_valid && !wr_ready
// ============================================================================
module wb_row_arbiter #(
   parameter int NUM_ROW = 8,
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 12
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [ADDR_W-1:0]           base_addr,
   input  logic [ADDR_W-1:0]           row_stride,
   input  logic [NUM_ROW-1:0]          row_valid,
   input  logic [NUM_ROW*DATA_W-1:0]   row_data,
   output logic [NUM_ROW-1:0]          row_ready,
   input  logic [NUM_ROW-1:0]          row_finish,
   output logic                        wr_valid,
   output logic [ADDR_W-1:0]           wr_addr,
   output logic [DATA_W-1:0]           wr_data,
   input  logic                        wr_ready,
   output logic                        busy,
   output logic                        layer_done
`ifdef WB_ROW_ARB_PERF_EN
   ,
   output logic [31:0]                 stall_cnt
`endif
);

   localparam int c_IDX_W = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [c_IDX_W-1:0]    r_last_grant;
   logic [ADDR_W-1:0]     r_addr_cnt [NUM_ROW];
   logic [NUM_ROW-1:0]    r_fin;

   logic                  w_can_load;
   logic                  w_any_valid;
   logic [c_IDX_W-1:0]    w_grant_idx;
   logic                  w_xfer;
   logic                  w_load;
   logic [ADDR_W-1:0]     w_sel_addr;
   logic [DATA_W-1:0]     w_sel_data;

   // ------------------------------------------------------------------------
   // Round-robin search: scan from last_grant+1 upward, wrapping, and take
   // the first valid row. Starting the scan just past the previous winner is
   // what gives every row a fair turn.
   // ------------------------------------------------------------------------
   always_comb begin
      int v_idx;
      w_any_valid = 1'b0;
      w_grant_idx = r_last_grant;
      v_idx       = 0;
      for (int k = 1; k <= NUM_ROW; k++) begin
         v_idx = int'(r_last_grant) + k;
         if (v_idx >= NUM_ROW) begin
            v_idx = v_idx - NUM_ROW;
         end
         if (!w_any_valid && row_valid[v_idx]) begin
            w_any_valid = 1'b1;
            w_grant_idx = c_IDX_W'(v_idx);
         end
      end
   end

   // The output stage can take a new beat when empty or retiring this cycle,
   // which allows back-to-back beats at full throughput.
   assign w_can_load = !wr_valid || wr_ready;
   assign w_xfer     = (r_state == S_RUN) && w_can_load && w_any_valid;
   assign w_load     = (r_state == S_IDLE) && start;

   assign row_ready  = w_xfer ? (NUM_ROW'(1) << w_grant_idx) : '0;
   assign w_sel_addr = r_addr_cnt[w_grant_idx];
   assign w_sel_data = row_data[w_grant_idx*DATA_W +: DATA_W];

   assign busy       = (r_state == S_RUN);
   assign layer_done = (r_state == S_DONE);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state. Completion looks at the registered sticky bits, so a
   // finish pulse is seen the cycle after it arrives; the output stage must
   // also be empty so the last beat has reached the buffer.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if ((&r_fin) && !wr_valid) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Per-row address counters and sticky finish flags
   // ------------------------------------------------------------------------
   generate
      for (genvar i = 0; i < NUM_ROW; i++) begin : g_row
         always_ff @(posedge clk) begin
            if (rst) begin
               r_addr_cnt[i] <= '0;
            end else if (w_load) begin
               // Row regions laid out at base + i*stride, wrapping in the
               // buffer address space.
               r_addr_cnt[i] <= base_addr + ADDR_W'(i) * row_stride;
            end else if (w_xfer && (w_grant_idx == c_IDX_W'(i))) begin
               r_addr_cnt[i] <= r_addr_cnt[i] + ADDR_W'(1);
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               r_fin[i] <= 1'b0;
            end else if (w_load) begin
               r_fin[i] <= 1'b0;
            end else if ((r_state == S_RUN) && row_finish[i]) begin
               r_fin[i] <= 1'b1;
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Round-robin pointer: only moves on a transfer, so an idle cycle leaves
   // the priority order untouched.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= c_IDX_W'(NUM_ROW - 1);
      end else if (w_xfer) begin
         r_last_grant <= w_grant_idx;
      end
   end

   // ------------------------------------------------------------------------
   // Output stage: single register, held while the buffer stalls.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else if (w_xfer) begin
         wr_valid <= 1'b1;
         wr_addr  <= w_sel_addr;
         wr_data  <= w_sel_data;
      end else if (wr_ready) begin
         wr_valid <= 1'b0;
      end
   end

`ifdef WB_ROW_ARB_PERF_EN
   // ------------------------------------------------------------------------
   // Back-pressure statistics: RUN cycles where the buffer refuses a beat.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (w_load) begin
         stall_cnt <= '0;
      end else if ((r_state == S_RUN) && wr_valid && !wr_ready &&
                   (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_row_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_row_arbiter
//  Description : Self-checking bench for wb_row_arbiter. A reference model
//                predicts grants, FSM status and write beats; predicted beats
//                are queued when a transfer is expected and compared when the
//                buffer retires them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_row_arbiter;

   localparam int NR = 8;
   localparam int DW = 8;
   localparam int AW = 12;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [AW-1:0]     base_addr;
   logic [AW-1:0]     row_stride;
   logic [NR-1:0]     row_valid;
   logic [NR*DW-1:0]  row_data;
   logic [NR-1:0]     row_ready;
   logic [NR-1:0]     row_finish;
   logic              wr_valid;
   logic [AW-1:0]     wr_addr;
   logic [DW-1:0]     wr_data;
   logic              wr_ready;
   logic              busy;
   logic              layer_done;
`ifdef WB_ROW_ARB_PERF_EN
   logic [31:0]       stall_cnt;
`endif

   always #5 clk = ~clk;

   wb_row_arbiter #(.NUM_ROW(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .row_stride (row_stride),
      .row_valid  (row_valid),
      .row_data   (row_data),
      .row_ready  (row_ready),
      .row_finish (row_finish),
      .wr_valid   (wr_valid),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .busy       (busy),
      .layer_done (layer_done)
`ifdef WB_ROW_ARB_PERF_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   int                m_state;       // 0 idle, 1 run, 2 done
   logic [AW-1:0]     m_addr [NR];
   int                m_last;
   logic              m_wv;
   logic [NR-1:0]     m_fin;
   logic [31:0]       m_stall;
   logic [AW+DW-1:0]  sb [$];
   logic [4:0]        seq [NR];
   logic [AW-1:0]     obs [$];

   task automatic reset_model();
      m_state = 0;
      for (int i = 0; i < NR; i++) m_addr[i] = '0;
      m_last  = NR - 1;
      m_wv    = 1'b0;
      m_fin   = '0;
      m_stall = '0;
      sb.delete();
   endtask

   // One clock: entered at a falling edge with inputs set, checks 1 ns later,
   // advances the model, returns at the next falling edge.
   task automatic cycle();
      int            g;
      int            nxt;
      int            idx;
      logic [NR-1:0] exp_ready;
      for (int i = 0; i < NR; i++) row_data[i*DW +: DW] = {3'(i), seq[i]};
      #1;
      g = -1;
      exp_ready = '0;
      if (m_state == 1 && (!m_wv || wr_ready)) begin
         for (int k = 1; k <= NR; k++) begin
            idx = (m_last + k) % NR;
            if (g < 0 && row_valid[idx]) g = idx;
         end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      check_eq("row_ready", 32'(row_ready), 32'(exp_ready));
      check_eq("wr_valid", 32'(wr_valid), 32'(m_wv));
      check_eq("busy", 32'(busy), 32'(m_state == 1));
      check_eq("layer_done", 32'(layer_done), 32'(m_state == 2));
`ifdef WB_ROW_ARB_PERF_EN
      check_eq("stall_cnt", stall_cnt, m_stall);
`endif
      if (m_wv && sb.size() > 0) begin
         check_eq("wr_addr", 32'(wr_addr), 32'(sb[0][AW+DW-1:DW]));
         check_eq("wr_data", 32'(wr_data), 32'(sb[0][DW-1:0]));
         if (wr_ready && !rst) begin
            void'(sb.pop_front());
            obs.push_back(wr_addr);
         end
      end
      if (rst) begin
         reset_model();
      end else begin
         nxt = m_state;
         case (m_state)
            0: if (start) begin
                  nxt = 1;
                  for (int i = 0; i < NR; i++) m_addr[i] = AW'(base_addr + AW'(i) * row_stride);
                  m_fin   = '0;
                  m_stall = '0;
               end
            1: if ((&m_fin) && !m_wv) nxt = 2;
            default: nxt = 0;
         endcase
         if (m_state == 1) begin
            if (m_wv && !wr_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            m_fin = m_fin | row_finish;
         end
         if (g >= 0) begin
            sb.push_back({m_addr[g], 3'(g), seq[g]});
            m_addr[g] = m_addr[g] + 1'b1;
            m_last    = g;
            seq[g]    = seq[g] + 1'b1;
            m_wv      = 1'b1;
         end else if (wr_ready) begin
            m_wv = 1'b0;
         end
         m_state = nxt;
      end
      @(negedge clk);
      start      = 1'b0;
      row_finish = '0;
   endtask

   task automatic kick(input logic [AW-1:0] b, input logic [AW-1:0] s);
      base_addr  = b;
      row_stride = s;
      start      = 1'b1;
      cycle();
   endtask

   // Stop requesting, finish all rows and let the layer complete.
   task automatic drain();
      int n;
      row_valid  = '0;
      wr_ready   = 1'b1;
      row_finish = '1;
      n = 0;
      while (n < 30 && m_state != 0) begin
         cycle();
         n++;
      end
      check_eq("drain_bound", 32'(m_state), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; row_stride = '0;
      row_valid = '0; row_finish = '0; wr_ready = 1'b0; row_data = '0;
      for (int i = 0; i < NR; i++) seq[i] = '0;
      reset_model();
      @(negedge clk);
      cycle();
      rst = 1'b0;
      check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
      check_eq("rst_wr_data", 32'(wr_data), 32'd0);
      cycle();

      // All rows valid, buffer always ready: strict rotation
      row_valid = '1;
      wr_ready  = 1'b1;
      obs.delete();
      kick(12'h100, 12'h040);
      for (int i = 0; i < 20; i++) cycle();
      for (int i = 0; i < 8; i++)
         check_eq("rr_addr", 32'(obs[i]), 32'h100 + 32'h40 * 32'(i));
      check_eq("rr_addr9", 32'(obs[8]), 32'h101);
      drain();

      // Rows 2 and 5, buffer ready toggling every cycle
      row_valid = 8'b0010_0100;
      kick(12'h000, 12'h010);
      for (int i = 0; i < 16; i++) begin
         wr_ready = i[0];
         cycle();
      end
      drain();

      // Address wrap at the top of the buffer
      obs.delete();
      row_valid = 8'h01;
      kick(12'hFFE, 12'h000);
      for (int i = 0; i < 4; i++) cycle();
      row_valid = '0;
      cycle();
      cycle();
      check_eq("wrap_a0", 32'(obs[0]), 32'hFFE);
      check_eq("wrap_a1", 32'(obs[1]), 32'hFFF);
      check_eq("wrap_a2", 32'(obs[2]), 32'h000);
      check_eq("wrap_a3", 32'(obs[3]), 32'h001);
      drain();

      // Finish everything while one beat is held by a stalled buffer
      kick(12'h200, 12'h008);
      row_valid = 8'h01;
      wr_ready  = 1'b0;
      cycle();
      row_valid = '0;
      for (int i = 0; i < 5; i++) begin
         if (i == 0) row_finish = '1;
         cycle();
      end
      wr_ready = 1'b1;
      drain();

      // start during RUN is ignored; row_valid in IDLE is not accepted
      row_valid = 8'h01;
      kick(12'h100, 12'h040);
      cycle();
      base_addr = 12'h800;
      start     = 1'b1;
      cycle();
      for (int i = 0; i < 3; i++) cycle();
      drain();
      row_valid = '1;
      for (int i = 0; i < 3; i++) cycle();
      row_valid = '0;

      // Long stall, then reset in the middle of RUN
      kick(12'h300, 12'h001);
      row_valid = 8'h80;
      wr_ready  = 1'b0;
      cycle();
      row_valid = '0;
      for (int i = 0; i < 10; i++) cycle();
`ifdef WB_ROW_ARB_PERF_EN
      check_eq("stall_10", stall_cnt, 32'd10);
`endif
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check_eq("mid_rst_addr", 32'(wr_addr), 32'd0);
      check_eq("mid_rst_data", 32'(wr_data), 32'd0);
      wr_ready = 1'b1;
      for (int i = 0; i < 3; i++) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
